// File: rtl/id_stage_pipe.sv
// RV32I decode stage with a built-in ID/EX output register.
// Decodes the instruction and picks operands from N forwarding ports or the
// register file. Load-use hazards are tracked against the output register and
// a one-entry shadow of the instruction now in EX. The result is presented to
// EX through a valid/ready handshake.
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int FWD_PORTS = 2,
    parameter int REG_AW    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [XLEN-1:0]             in_pc,
    input  logic [31:0]                 in_inst,
    output logic [REG_AW-1:0]           rf_raddr1,
    output logic [REG_AW-1:0]           rf_raddr2,
    input  logic [XLEN-1:0]             rf_rdata1,
    input  logic [XLEN-1:0]             rf_rdata2,
    input  logic [FWD_PORTS-1:0]        fwd_we,
    input  logic [FWD_PORTS*REG_AW-1:0] fwd_addr,
    input  logic [FWD_PORTS*XLEN-1:0]   fwd_data,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_pc,
    output logic [XLEN-1:0]             out_imm,
    output logic [XLEN-1:0]             out_rs1_val,
    output logic [XLEN-1:0]             out_rs2_val,
    output logic [3:0]                  out_cls,
    output logic [3:0]                  out_funct,
    output logic [REG_AW-1:0]           out_rd,
    output logic                        out_we,
    output logic                        out_illegal
);

    localparam logic [3:0] CLS_NONE   = 4'd0;
    localparam logic [3:0] CLS_LUI    = 4'd1;
    localparam logic [3:0] CLS_AUIPC  = 4'd2;
    localparam logic [3:0] CLS_JAL    = 4'd3;
    localparam logic [3:0] CLS_JALR   = 4'd4;
    localparam logic [3:0] CLS_BRANCH = 4'd5;
    localparam logic [3:0] CLS_LOAD   = 4'd6;
    localparam logic [3:0] CLS_STORE  = 4'd7;
    localparam logic [3:0] CLS_OPIMM  = 4'd8;
    localparam logic [3:0] CLS_OP     = 4'd9;

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic [REG_AW-1:0] rd_field_s;
    logic [REG_AW-1:0] rs1_s;
    logic [REG_AW-1:0] rs2_s;
    logic [3:0]        cls_s;
    logic [31:0]       imm32_s;
    logic [XLEN-1:0]   imm_s;
    logic              use_rs1_s;
    logic              use_rs2_s;
    logic              writes_s;
    logic              has_f3_s;
    logic              alt_s;
    logic              we_s;
    logic [REG_AW-1:0] rd_s;
    logic [XLEN-1:0]   rs1_val_s;
    logic [XLEN-1:0]   rs2_val_s;
    logic              ld_out_s;
    logic              hazard_s;
    logic              sh_valid_r;
    logic [REG_AW-1:0] sh_rd_r;

    // Youngest matching forwarding port wins; unused or x0 sources read as zero.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [REG_AW-1:0]           rs,
        input logic                        used,
        input logic [XLEN-1:0]             rf_val,
        input logic [FWD_PORTS-1:0]        we,
        input logic [FWD_PORTS*REG_AW-1:0] addr,
        input logic [FWD_PORTS*XLEN-1:0]   data
    );
        logic [XLEN-1:0] val;
        val = {XLEN{1'b0}};
        if (used && (rs != REG_ZERO)) begin
            val = rf_val;
            for (int i = FWD_PORTS - 1; i >= 0; i--) begin
                if (we[i] && (addr[i*REG_AW +: REG_AW] == rs)) begin
                    val = data[i*XLEN +: XLEN];
                end
            end
        end
        return val;
    endfunction

    assign opcode_s   = in_inst[6:0];
    assign funct3_s   = in_inst[14:12];
    assign rd_field_s = REG_AW'(in_inst[11:7]);
    assign rs1_s      = REG_AW'(in_inst[19:15]);
    assign rs2_s      = REG_AW'(in_inst[24:20]);
    assign rf_raddr1  = rs1_s;
    assign rf_raddr2  = rs2_s;

    // Opcode decode: class, immediate format and register usage.
    always_comb begin
        cls_s     = CLS_NONE;
        imm32_s   = 32'd0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        writes_s  = 1'b0;
        has_f3_s  = 1'b0;
        alt_s     = 1'b0;
        case (opcode_s)
            7'b0110111: begin
                cls_s    = CLS_LUI;
                imm32_s  = {in_inst[31:12], 12'd0};
                writes_s = 1'b1;
            end
            7'b0010111: begin
                cls_s    = CLS_AUIPC;
                imm32_s  = {in_inst[31:12], 12'd0};
                writes_s = 1'b1;
            end
            7'b1101111: begin
                cls_s    = CLS_JAL;
                imm32_s  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
                writes_s = 1'b1;
            end
            7'b1100111: begin
                cls_s     = CLS_JALR;
                imm32_s   = {{20{in_inst[31]}}, in_inst[31:20]};
                use_rs1_s = 1'b1;
                writes_s  = 1'b1;
                has_f3_s  = 1'b1;
            end
            7'b1100011: begin
                cls_s     = CLS_BRANCH;
                imm32_s   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                has_f3_s  = 1'b1;
            end
            7'b0000011: begin
                cls_s     = CLS_LOAD;
                imm32_s   = {{20{in_inst[31]}}, in_inst[31:20]};
                use_rs1_s = 1'b1;
                writes_s  = 1'b1;
                has_f3_s  = 1'b1;
            end
            7'b0100011: begin
                cls_s     = CLS_STORE;
                imm32_s   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                has_f3_s  = 1'b1;
            end
            7'b0010011: begin
                cls_s     = CLS_OPIMM;
                imm32_s   = {{20{in_inst[31]}}, in_inst[31:20]};
                use_rs1_s = 1'b1;
                writes_s  = 1'b1;
                has_f3_s  = 1'b1;
                // bit 30 only distinguishes SRLI/SRAI (and SLLI) among immediates
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    alt_s = in_inst[30];
                end else begin
                    alt_s = 1'b0;
                end
            end
            7'b0110011: begin
                cls_s     = CLS_OP;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                writes_s  = 1'b1;
                has_f3_s  = 1'b1;
                alt_s     = in_inst[30];
            end
            default: begin
                cls_s = CLS_NONE;
            end
        endcase
    end

    assign imm_s = XLEN'($signed(imm32_s));
    assign we_s  = writes_s & (rd_field_s != REG_ZERO);
    assign rd_s  = writes_s ? rd_field_s : REG_ZERO;

    // Operand selection from forwarding ports or register file.
    always_comb begin
        rs1_val_s = sel_operand(rs1_s, use_rs1_s, rf_rdata1, fwd_we, fwd_addr, fwd_data);
        rs2_val_s = sel_operand(rs2_s, use_rs2_s, rf_rdata2, fwd_we, fwd_addr, fwd_data);
    end

    // Load-use hazard against the load in the output register or in EX.
    always_comb begin
        ld_out_s = out_valid & (out_cls == CLS_LOAD);
        hazard_s = 1'b0;
        if (in_valid) begin
            hazard_s =
                (use_rs1_s && (rs1_s != REG_ZERO) &&
                 ((ld_out_s && (out_rd == rs1_s)) || (sh_valid_r && (sh_rd_r == rs1_s)))) ||
                (use_rs2_s && (rs2_s != REG_ZERO) &&
                 ((ld_out_s && (out_rd == rs2_s)) || (sh_valid_r && (sh_rd_r == rs2_s))));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign in_ready = rst & ~hazard_s & (~out_valid | out_ready);

    // ID/EX output register: flush kills, transfer loads, advance leaves a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_pc      <= {XLEN{1'b0}};
            out_imm     <= {XLEN{1'b0}};
            out_rs1_val <= {XLEN{1'b0}};
            out_rs2_val <= {XLEN{1'b0}};
            out_cls     <= 4'd0;
            out_funct   <= 4'd0;
            out_rd      <= REG_ZERO;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_imm     <= imm_s;
            out_rs1_val <= rs1_val_s;
            out_rs2_val <= rs2_val_s;
            out_cls     <= cls_s;
            out_funct   <= {alt_s, (has_f3_s ? funct3_s : 3'd0)};
            out_rd      <= rd_s;
            out_we      <= we_s;
            out_illegal <= (cls_s == CLS_NONE);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Shadow of the instruction that moved into EX, kept only if it is a writing load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_valid_r <= 1'b0;
            sh_rd_r    <= REG_ZERO;
        end else if (out_ready) begin
            sh_valid_r <= out_valid & (out_cls == CLS_LOAD) & out_we;
            sh_rd_r    <= out_rd;
        end else begin
            sh_valid_r <= sh_valid_r;
            sh_rd_r    <= sh_rd_r;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed-vector bench for id_stage_pipe with a queue-based scoreboard.
module tb_id_stage_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  cls;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [3:0]  out_cls;
    logic [3:0]  out_funct;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] pc_ctr = 32'h0000_0100;
    int   st;
    int   bb;

    id_stage_pipe #(.XLEN(32), .FWD_PORTS(2), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_cls(out_cls), .out_funct(out_funct), .out_rd(out_rd),
        .out_we(out_we), .out_illegal(out_illegal)
    );

    // Register file model: every register (x0 included) holds 0x1000_0000 + index.
    assign rf_rdata1 = 32'h1000_0000 | {27'd0, rf_raddr1};
    assign rf_rdata2 = 32'h1000_0000 | {27'd0, rf_raddr2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] cls, input logic [3:0] funct,
                                input logic [4:0] rd, input logic we, input logic ill,
                                input logic [31:0] imm, input logic [31:0] rs1,
                                input logic [31:0] rs2);
        exp_t e;
        e.pc = 32'd0; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2;
        e.cls = cls; e.funct = funct; e.rd = rd; e.we = we; e.ill = ill;
        return e;
    endfunction

    task automatic set_fwd(input int p, input logic we, input logic [4:0] a, input logic [31:0] d);
        fwd_we[p]          = we;
        fwd_addr[p*5 +: 5] = a;
        fwd_data[p*32 +: 32] = d;
    endtask

    task automatic fwd_off();
        fwd_we   = 2'b00;
        fwd_addr = 10'd0;
        fwd_data = 64'd0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers an instruction until accepted; counts stall cycles and empty-output cycles.
    task automatic send(input string name, input logic [31:0] inst, input exp_t e,
                        input bit push, input int exp_stalls, input int exp_bubs);
        int  stalls;
        int  bubs;
        bit  done;
        exp_t ee;
        ee       = e;
        ee.pc    = pc_ctr;
        in_pc    = pc_ctr;
        pc_ctr   = pc_ctr + 32'd4;
        in_inst  = inst;
        in_valid = 1'b1;
        stalls   = 0;
        bubs     = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!out_valid) bubs++;
            if (in_ready) begin
                if (push) exp_q.push_back(ee);
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 20) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_timeout: no accept after %0d cycles", name, stalls);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check({name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
        if (exp_bubs >= 0) check({name, "_bubbles"}, 64'(bubs), 64'(exp_bubs));
    endtask

    // Scoreboard monitor: every bundle EX takes must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got bundle pc=%0h expected none", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_pc",    64'(out_pc),      64'(mon_e.pc));
                check("sb_imm",   64'(out_imm),     64'(mon_e.imm));
                check("sb_rs1",   64'(out_rs1_val), 64'(mon_e.rs1));
                check("sb_rs2",   64'(out_rs2_val), 64'(mon_e.rs2));
                check("sb_cls",   64'(out_cls),     64'(mon_e.cls));
                check("sb_funct", 64'(out_funct),   64'(mon_e.funct));
                check("sb_rd",    64'(out_rd),      64'(mon_e.rd));
                check("sb_we",    64'(out_we),      64'(mon_e.we));
                check("sb_ill",   64'(out_illegal), 64'(mon_e.ill));
            end
        end
    end

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'd0;
        in_inst   = 32'h0000_0013;
        flush     = 1'b0;
        out_ready = 1'b1;
        fwd_off();

        // reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_pc",  64'(out_pc), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_ops", {out_rs1_val, out_rs2_val}, 64'd0);
        check("rst_ctl", 64'({out_cls, out_funct, out_rd, out_we, out_illegal}), 64'd0);
        in_valid = 1'b0;
        #21;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back forwarding from EX port
        send("addi_x1", 32'h0050_0093, mk(4'd8, 4'd0, 5'd1, 1'b1, 1'b0, 32'd5, 32'd0, 32'd0), 1'b1, 0, -1);
        set_fwd(0, 1'b1, 5'd1, 32'd5);
        send("add_fwd", 32'h0010_8133, mk(4'd9, 4'd0, 5'd2, 1'b1, 1'b0, 32'd0, 32'd5, 32'd5), 1'b1, 0, 0);

        // forwarding priority: port 0 beats port 1
        set_fwd(0, 1'b1, 5'd3, 32'h0000_AAAA);
        set_fwd(1, 1'b1, 5'd3, 32'h0000_5555);
        send("or_prio", 32'h0001_E233, mk(4'd9, 4'd6, 5'd4, 1'b1, 1'b0, 32'd0, 32'h0000_AAAA, 32'd0), 1'b1, 0, 0);
        fwd_off();

        // decode coverage across formats
        send("lui",   32'h1234_01B7, mk(4'd1, 4'd0, 5'd3, 1'b1, 1'b0, 32'h1234_0000, 32'd0, 32'd0), 1'b1, 0, 0);
        send("auipc", 32'h0001_0217, mk(4'd2, 4'd0, 5'd4, 1'b1, 1'b0, 32'h0001_0000, 32'd0, 32'd0), 1'b1, 0, 0);
        send("jal",   32'h0080_00EF, mk(4'd3, 4'd0, 5'd1, 1'b1, 1'b0, 32'd8, 32'd0, 32'd0), 1'b1, 0, 0);
        send("sw",    32'hFE20_AE23, mk(4'd7, 4'd2, 5'd0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h1000_0001, 32'h1000_0002), 1'b1, 0, 0);
        send("beq",   32'hFE20_8CE3, mk(4'd5, 4'd0, 5'd0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h1000_0001, 32'h1000_0002), 1'b1, 0, 0);
        send("srai",  32'h4033_5293, mk(4'd8, 4'hD, 5'd5, 1'b1, 1'b0, 32'h0000_0403, 32'h1000_0006, 32'd0), 1'b1, 0, 0);
        send("sub",   32'h4020_8433, mk(4'd9, 4'd8, 5'd8, 1'b1, 1'b0, 32'd0, 32'h1000_0001, 32'h1000_0002), 1'b1, 0, 0);
        send("addi_neg", 32'hC000_0093, mk(4'd8, 4'd0, 5'd1, 1'b1, 1'b0, 32'hFFFF_FC00, 32'd0, 32'd0), 1'b1, 0, 0);
        send("addi_x0",  32'h0010_0013, mk(4'd8, 4'd0, 5'd0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0), 1'b1, 0, 0);
        send("illegal",  32'h0000_007F, mk(4'd0, 4'd0, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0), 1'b1, 0, 0);

        // load-use with the load still in the output register: 2 bubbles
        send("lw_a", 32'h0003_2283, mk(4'd6, 4'd2, 5'd5, 1'b1, 1'b0, 32'd0, 32'h1000_0006, 32'd0), 1'b1, 0, 0);
        set_fwd(1, 1'b1, 5'd5, 32'h0000_1234);
        send("use_a", 32'h0002_83B3, mk(4'd9, 4'd0, 5'd7, 1'b1, 1'b0, 32'd0, 32'h0000_1234, 32'd0), 1'b1, 2, 2);
        fwd_off();

        // load-use with the load already in EX: 1 bubble
        send("lw_b", 32'h0003_2283, mk(4'd6, 4'd2, 5'd5, 1'b1, 1'b0, 32'd0, 32'h1000_0006, 32'd0), 1'b1, 0, 0);
        send("indep", 32'h0030_0413, mk(4'd8, 4'd0, 5'd8, 1'b1, 1'b0, 32'd3, 32'd0, 32'd0), 1'b1, 0, 0);
        set_fwd(1, 1'b1, 5'd5, 32'h0000_1234);
        send("use_b", 32'h0002_83B3, mk(4'd9, 4'd0, 5'd7, 1'b1, 1'b0, 32'd0, 32'h0000_1234, 32'd0), 1'b1, 1, 1);
        fwd_off();

        // flush of a held bundle under back-pressure, then flush with in_ready high
        idle(1);
        out_ready = 1'b0;
        send("held", 32'h0070_0493, mk(4'd8, 4'd0, 5'd9, 1'b1, 1'b0, 32'd7, 32'd0, 32'd0), 1'b0, 0, -1);
        in_inst  = 32'h00A0_0513;
        in_pc    = pc_ctr;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_hold_valid", 64'(out_valid), 64'd1);
        check("bp_in_ready",      64'(in_ready),  64'd0);
        @(posedge clk);
        #1;
        check("flush_kill", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_no_issue", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

        // reset asserted during a load-use stall
        send("lw_c", 32'h0003_2283, mk(4'd6, 4'd2, 5'd5, 1'b1, 1'b0, 32'd0, 32'h1000_0006, 32'd0), 1'b1, 0, -1);
        in_inst  = 32'h0002_83B3;
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_before_rst", 64'(in_ready), 64'd0);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_mid_valid",    64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready),  64'd0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send("after_rst", 32'h0002_83B3, mk(4'd9, 4'd0, 5'd7, 1'b1, 1'b0, 32'd0, 32'h1000_0005, 32'd0), 1'b1, 0, -1);

        idle(3);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
